// File: rtl/user_ram_pkg.sv
// Shared definitions for the user RAM bridge and the byte-merge datapath.
package user_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [3:0]  WSTRB_FULL     = 4'hF;
  localparam logic [31:0] USER_RAM_BASE  = 32'h0002_0000;

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational byte merge: strobed bytes come from new_data, the rest from old_data.
module ram_byte_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign merged[8*gi +: 8] = wstrb[gi] ? new_data[8*gi +: 8] : old_data[8*gi +: 8];
  end

endmodule

// File: rtl/user_ram_bridge.sv
// CPU native-bus to user RAM bridge: window decode, read / write / read-modify-write sequencing.
module user_ram_bridge
  import user_ram_pkg::*;
#(
  parameter int          ADDR_BIT  = 8,
  parameter logic [31:0] BASE_ADDR = USER_RAM_BASE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic                mem_ready_o,
  output logic [31:0]         mem_rdata_o,
  output logic                ram_wr_en_o,
  output logic                ram_rd_en_o,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  output logic [31:0]         ram_di_o,
  input  logic [31:0]         ram_do_i
);

  state_t              state_reg, state_next;
  logic [31:0]         wdata_reg, wdata_next;
  logic [3:0]          wstrb_reg, wstrb_next;
  logic                ready_next, wr_en_next, rd_en_next;
  logic [31:0]         rdata_next, di_next;
  logic [ADDR_BIT-1:0] addr_next;
  logic [31:0]         merged;
  logic                sel;
  logic                unused_byte_offset;

  // Byte offset is irrelevant: every access targets the whole word.
  assign unused_byte_offset = ^mem_addr_i[1:0];

  assign sel = mem_valid_i && (mem_addr_i[31:ADDR_BIT+2] == BASE_ADDR[31:ADDR_BIT+2]);

  ram_byte_merge u_merge (
    .old_data (ram_do_i),
    .new_data (wdata_reg),
    .wstrb    (wstrb_reg),
    .merged   (merged)
  );

  always_comb begin
    state_next = state_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    ready_next = 1'b0;
    wr_en_next = 1'b0;
    rd_en_next = 1'b0;
    rdata_next = mem_rdata_o;
    addr_next  = ram_addr_o;
    di_next    = ram_di_o;
    case (state_reg)
      ST_IDLE: begin
        if (sel) begin
          addr_next  = mem_addr_i[ADDR_BIT+1:2];
          wdata_next = mem_wdata_i;
          wstrb_next = mem_wstrb_i;
          if (mem_wstrb_i == WSTRB_FULL) begin
            state_next = ST_WR;
            wr_en_next = 1'b1;
            di_next    = mem_wdata_i;
          end else begin
            state_next = ST_RD;
            rd_en_next = 1'b1;
          end
        end
      end
      ST_RD: begin
        state_next = ST_CAP;
        rd_en_next = 1'b1;
      end
      ST_CAP: begin
        // RAM data is valid here; either return it or merge it into the pending store.
        if (wstrb_reg == 4'h0) begin
          state_next = ST_RESP;
          rdata_next = ram_do_i;
          ready_next = 1'b1;
        end else begin
          state_next = ST_WR;
          wr_en_next = 1'b1;
          di_next    = merged;
        end
      end
      ST_WR: begin
        state_next = ST_RESP;
        ready_next = 1'b1;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      ram_wr_en_o <= 1'b0;
      ram_rd_en_o <= 1'b0;
      ram_addr_o  <= '0;
      ram_di_o    <= '0;
    end else begin
      state_reg   <= state_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      mem_ready_o <= ready_next;
      mem_rdata_o <= rdata_next;
      ram_wr_en_o <= wr_en_next;
      ram_rd_en_o <= rd_en_next;
      ram_addr_o  <= addr_next;
      ram_di_o    <= di_next;
    end
  end

endmodule
